// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU command codes, sequencer opcodes, states and flag positions
package alu_seq_pkg;
    localparam int REGISTER_LEN = 32;
    localparam int CMD_W = 4;
    localparam logic [CMD_W-1:0] AND_EXE = 4'd0;
    localparam logic [CMD_W-1:0] EOR_EXE = 4'd1;
    localparam logic [CMD_W-1:0] ADC_EXE = 4'd5;
    localparam logic [CMD_W-1:0] ORR_EXE = 4'd12;
    localparam logic [CMD_W-1:0] MOV_EXE = 4'd13;
    localparam logic [CMD_W-1:0] MVN_EXE = 4'd15;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [2:0] {
        SEQ_OP_ADD = 3'd0,
        SEQ_OP_SUB = 3'd1,
        SEQ_OP_AND = 3'd2,
        SEQ_OP_ORR = 3'd3,
        SEQ_OP_EOR = 3'd4,
        SEQ_OP_MOV = 3'd5,
        SEQ_OP_MVN = 3'd6,
        SEQ_OP_ILL = 3'd7
    } seq_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} seq_state_e;
    function automatic logic op_legal(input logic [2:0] op);
        return op != SEQ_OP_ILL;
    endfunction
endpackage

// File: rtl/alu_seq_opmap.sv
// alu_seq_opmap: maps (op, pass) to ALU command, operand-B inversion and carry-in source
// Ports: op (sequencer opcode), pass (0 = low word, 1 = high word) ->
//   command, inv_b (invert B for subtract), cin_init (constant carry-in),
//   chain (carry-in comes from the low-pass carry)
module alu_seq_opmap
    import alu_seq_pkg::*;
(
    input  logic [2:0]       op,
    input  logic             pass,
    output logic [CMD_W-1:0] command,
    output logic             inv_b,
    output logic             cin_init,
    output logic             chain
);
    logic arith;
    always_comb begin
        arith    = op == SEQ_OP_ADD || op == SEQ_OP_SUB;
        command  = arith ? ADC_EXE :
                   op == SEQ_OP_AND ? AND_EXE :
                   op == SEQ_OP_ORR ? ORR_EXE :
                   op == SEQ_OP_EOR ? EOR_EXE :
                   op == SEQ_OP_MVN ? MVN_EXE : MOV_EXE;
        inv_b    = op == SEQ_OP_SUB;
        cin_init = op == SEQ_OP_SUB && !pass;
        chain    = arith && pass;
    end
endmodule

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 64-bit ops on the shared 32-bit ALU as a low pass then a high pass
// Ports: clk, rst (async active-high); req_* valid/ready request (op, wide, a, b);
//   resp_* valid/ready response (result, flags {Z,C,N,V}, err for illegal op);
//   alu_in1/alu_in2/alu_command/alu_cin drive the ALU, alu_out/alu_status come back.
// Optional: define ALU_SEQ_BYPASS_EN to run req_wide=0 requests as a single 32-bit pass.
module alu_wide_sequencer
    import alu_seq_pkg::*;
#(
    parameter int REG_LEN = REGISTER_LEN,
    parameter int CMD_LEN = CMD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic                 req_wide,
    input  logic [2*REG_LEN-1:0] req_a,
    input  logic [2*REG_LEN-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*REG_LEN-1:0] resp_result,
    output logic [3:0]           resp_flags,
    output logic                 resp_err,
    output logic [REG_LEN-1:0]   alu_in1,
    output logic [REG_LEN-1:0]   alu_in2,
    output logic [CMD_LEN-1:0]   alu_command,
    output logic                 alu_cin,
    input  logic [REG_LEN-1:0]   alu_out,
    input  logic [3:0]           alu_status
);
    seq_state_e             state, state_nxt;
    logic [2:0]             op_q;
    logic [2*REG_LEN-1:0]   a_q, b_q, res_q;
    logic [3:0]             flags_q;
    logic                   err_q, c_lo, z_lo, narrow_q, narrow_req;
    logic                   pass, busy, accept;
    logic [CMD_W-1:0]       cmd;
    logic                   inv_b, cin_init, chain;
    logic [REG_LEN-1:0]     a_half, b_half;

`ifdef ALU_SEQ_BYPASS_EN
    assign narrow_req = !req_wide;
`else
    logic unused_wide;
    assign narrow_req  = 1'b0;
    assign unused_wide = req_wide;
`endif

    alu_seq_opmap u_opmap (
        .op       (op_q),
        .pass     (pass),
        .command  (cmd),
        .inv_b    (inv_b),
        .cin_init (cin_init),
        .chain    (chain)
    );

    always_comb begin
        pass        = state == ST_HI;
        busy        = state == ST_LO || state == ST_HI;
        accept      = state == ST_IDLE && req_valid;
        state_nxt   = state == ST_IDLE ? (req_valid ? (op_legal(req_op) ? ST_LO : ST_DONE) : ST_IDLE) :
                      state == ST_LO   ? (narrow_q ? ST_DONE : ST_HI) :
                      state == ST_HI   ? ST_DONE :
                      resp_ready       ? ST_IDLE : ST_DONE;
        a_half      = pass ? a_q[2*REG_LEN-1:REG_LEN] : a_q[REG_LEN-1:0];
        b_half      = (pass ? b_q[2*REG_LEN-1:REG_LEN] : b_q[REG_LEN-1:0]) ^ {REG_LEN{inv_b}};
        alu_in1     = busy ? a_half : '0;
        alu_in2     = busy ? b_half : '0;
        alu_command = busy ? CMD_LEN'(cmd) : CMD_LEN'(MOV_EXE);
        alu_cin     = busy && (cin_init || (chain && c_lo));
        req_ready   = state == ST_IDLE;
        resp_valid  = state == ST_DONE;
        resp_result = res_q;
        resp_flags  = flags_q;
        resp_err    = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            narrow_q <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            c_lo     <= 1'b0;
            z_lo     <= 1'b0;
        end else begin
            state <= state_nxt;
            // Clearing on accept gives the illegal-op response its zero result/flags.
            if (accept) begin
                op_q     <= req_op;
                a_q      <= req_a;
                b_q      <= req_b;
                narrow_q <= narrow_req;
                err_q    <= !op_legal(req_op);
                res_q    <= '0;
                flags_q  <= '0;
            end
            if (state == ST_LO) begin
                res_q[REG_LEN-1:0] <= alu_out;
                c_lo               <= alu_status[FLAG_C];
                z_lo               <= alu_status[FLAG_Z];
                if (narrow_q)
                    flags_q <= alu_status;
            end
            if (state == ST_HI) begin
                res_q[2*REG_LEN-1:REG_LEN] <= alu_out;
                flags_q <= {z_lo & alu_status[FLAG_Z], alu_status[FLAG_C],
                            alu_status[FLAG_N], alu_status[FLAG_V]};
            end
        end
    end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: directed and random checks of the wide sequencer against a 64-bit reference
module tb_alu_wide_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic        req_wide = 1'b1;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_result;
    logic [3:0]  resp_flags;
    logic        resp_err;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_command, alu_status;
    logic        alu_cin;
    logic [32:0] alu_sum;
    logic        alu_c, alu_v;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_wide    (req_wide),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .resp_err    (resp_err),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_command (alu_command),
        .alu_cin     (alu_cin),
        .alu_out     (alu_out),
        .alu_status  (alu_status)
    );

    // Combinational 32-bit EXE ALU the sequencer drives.
    always_comb begin
        alu_sum    = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_cin};
        alu_out    = alu_command == ADC_EXE ? alu_sum[31:0] :
                     alu_command == AND_EXE ? alu_in1 & alu_in2 :
                     alu_command == ORR_EXE ? alu_in1 | alu_in2 :
                     alu_command == EOR_EXE ? alu_in1 ^ alu_in2 :
                     alu_command == MVN_EXE ? ~alu_in2 : alu_in2;
        alu_c      = alu_command == ADC_EXE && alu_sum[32];
        alu_v      = alu_command == ADC_EXE && alu_in1[31] == alu_in2[31] && alu_out[31] != alu_in1[31];
        alu_status = {alu_out == 32'd0, alu_c, alu_out[31], alu_v};
    end

    // Whole-operation reference: plain 64-bit (or 32-bit narrow) arithmetic.
    function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic wide, output logic [63:0] r, output logic [3:0] f,
                                  output logic e, output int lat);
        int w;
        logic [63:0] m, am, bm;
        logic [64:0] s;
        logic c, v, sa, sb;
        w = 64;
`ifdef ALU_SEQ_BYPASS_EN
        if (!wide) w = 32;
`else
        if (wide === 1'bx) w = 64;
`endif
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        am = a & m;
        bm = b & m;
        sa = am[w-1];
        sb = bm[w-1];
        c = 1'b0;
        v = 1'b0;
        e = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                s = {1'b0, am} + {1'b0, bm};
                r = s[63:0] & m;
                c = (w == 64) ? s[64] : s[32];
                v = sa == sb && r[w-1] != sa;
            end
            3'd1: begin
                r = (am - bm) & m;
                c = am >= bm;
                v = sa != sb && r[w-1] != sa;
            end
            3'd2: r = am & bm;
            3'd3: r = am | bm;
            3'd4: r = am ^ bm;
            3'd5: r = bm;
            3'd6: r = ~bm & m;
            default: e = 1'b1;
        endcase
        f   = e ? 4'b0 : {r == 64'd0, c, r[w-1], v};
        lat = e ? 0 : (w == 64 ? 2 : 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic wide, input int hold);
        logic [63:0] er;
        logic [3:0]  ef;
        logic        ee;
        int          el, cyc;
        model(op, a, b, wide, er, ef, ee, el);
        @(negedge clk);
        chk("req_ready before accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_wide  = wide;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        cyc = 0;
        while (!resp_valid && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(el));
        chk("alu idle cmd in done", 64'(alu_command), 64'(MOV_EXE));
        chk("alu idle operands in done", {alu_in1, alu_in2}, 64'd0);
        chk("alu idle cin in done", 64'(alu_cin), 64'd0);
        for (int i = 0; i <= hold; i++) begin
            chk("result", resp_result, er);
            chk("flags", 64'(resp_flags), 64'(ef));
            chk("err", 64'(resp_err), 64'(ee));
            chk("resp_valid held", 64'(resp_valid), 64'd1);
            chk("req_ready busy", 64'(req_ready), 64'd0);
            if (i < hold) begin
                if (i == 1) begin
                    req_valid = 1'b1;
                    req_op    = 3'd0;
                    req_a     = 64'd5;
                    req_b     = 64'd6;
                end
                @(posedge clk);
                #1;
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("resp_valid after handshake", 64'(resp_valid), 64'd0);
        chk("req_ready after handshake", 64'(req_ready), 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 4))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_result", resp_result, 64'd0);
        chk("reset resp_flags", 64'(resp_flags), 64'd0);
        chk("reset resp_err", 64'(resp_err), 64'd0);
        chk("reset alu_command", 64'(alu_command), 64'(MOV_EXE));
        chk("reset alu operands", {alu_in1, alu_in2}, 64'd0);
        chk("reset alu_cin", 64'(alu_cin), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        txn(3'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 0);
        txn(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0);
        txn(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0);
        txn(3'd1, 64'd0, 64'd1, 1'b1, 0);
        txn(3'd4, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);
        txn(3'd7, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1, 0);
        txn(3'd2, 64'hF0F0_1234_FFFF_0000, 64'h0FF0_FFFF_00FF_FF00, 1'b1, 5);

        // Reset in the middle of the high pass.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 64'h0000_0001_FFFF_FFFF;
        req_b     = 64'd1;
        req_wide  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst mid HI resp_valid", 64'(resp_valid), 64'd0);
        chk("rst mid HI req_ready", 64'(req_ready), 64'd1);
        chk("rst mid HI result", resp_result, 64'd0);
        chk("rst mid HI alu_command", 64'(alu_command), 64'(MOV_EXE));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after rst no response", 64'(resp_valid), 64'd0);

`ifdef ALU_SEQ_BYPASS_EN
        txn(3'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0);
        txn(3'd1, 64'hABCD_0000_0000_0005, 64'h1234_0000_0000_0007, 1'b0, 0);
`endif

        for (int k = 0; k < 60; k++)
            txn(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 2 : 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Controller that sequences the shared 32-bit EXE-stage ALU to perform 64-bit operations in two ALU passes (low word, then high word), chaining carry between passes.
- Sits beside the ALU in the execute stage. Owns the ALU operand, command and cin inputs while busy. Presents a valid/ready request port and a valid/ready response port to the pipeline control.

Parameters:
- REG_LEN, 32, ALU word width; operands and results are 2*REG_LEN.
- CMD_LEN, 4, ALU command width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  3  operation code (SEQ_OP_*)
- req_wide  input  1  1 = 64-bit operation; 0 = 32-bit (used only with ALU_SEQ_BYPASS_EN)
- req_a  input  2*REG_LEN  operand A
- req_b  input  2*REG_LEN  operand B
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_result  output  2*REG_LEN  result
- resp_flags  output  4  {Z,C,N,V}
- resp_err  output  1  illegal opcode
- alu_in1  output  REG_LEN  to ALU
- alu_in2  output  REG_LEN  to ALU
- alu_command  output  CMD_LEN  to ALU
- alu_cin  output  1  to ALU
- alu_out  input  REG_LEN  from ALU
- alu_status  input  4  from ALU, {Z,C,N,V}

Behaviour:
- States: IDLE, LO, HI, DONE. Reset to IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_result=0, resp_flags=0, resp_err=0. ALU drive in reset: in1=0, in2=0, command=MOV_EXE, cin=0.
- The ALU is combinational, so each pass takes one cycle.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch op, a, b, wide; go to LO.
  - ALU is driven with MOV_EXE and zeros.
- LO:
  - Drive a[31:0] and b'[31:0].
  - At the edge, capture lo=alu_out, c_lo=alu_status[C], z_lo=alu_status[Z]; go to HI.
- HI:
  - Drive a[63:32], b'[63:32], cin=c_lo.
  - At the edge, capture hi=alu_out and the flags; go to DONE.
- DONE:
  - resp_valid=1; result and flags held stable.
  - On resp_ready, go to IDLE.
  - req_ready=0 in all states except IDLE. No request overlap.
- Latency: resp_valid rises 2 edges after the accepting edge.
- Op mapping (b' = b unless noted):
  - ADD: LO uses ADC_EXE with cin=0; HI uses ADC_EXE with cin=c_lo.
  - SUB: b'=~b. LO uses ADC_EXE with cin=1; HI uses ADC_EXE with cin=c_lo. C=1 means no borrow.
  - AND, ORR, EOR, MOV, MVN: same command on both halves; cin=0.
  - op 7 is illegal: skip LO/HI, go IDLE->DONE with result=0, flags=0, resp_err=1.
- Flags (64-bit ops):
  - Z = z_lo & z_hi.
  - N, C, V taken from the HI pass.
  - Logic ops report C=V=0, as the ALU does.
- Reset asserted in any state (including mid-LO/HI): immediately IDLE with reset values; partial results discarded.
- req_valid while busy is ignored; the requester must hold its request.

Optional Feature:
- Macro ALU_SEQ_BYPASS_EN.
- Defined: req_wide=0 runs a single pass, IDLE->LO->DONE.
  - resp_result = {32'b0, lo}; flags come directly from the LO pass.
  - resp_valid rises 1 edge after accept.
- Undefined: req_wide is ignored; every operation is 64-bit.

Decomposition:
- Shared package/defines: SEQ_OP_ADD=0, SUB=1, AND=2, ORR=3, EOR=4, MOV=5, MVN=6; state encodings; reuse the existing *_EXE command constants and REGISTER_LEN.
- One sub-module: alu_seq_opmap, combinational. Maps (op, pass) to command, operand-B inversion and initial cin.

Test Plan:
- ADD 0x00000000_FFFFFFFF + 0x1 -> 0x00000001_00000000, flags Z0 C0 N0 V0, resp_valid 2 edges after accept.
- ADD 0xFFFFFFFF_FFFFFFFF + 0x1 -> 0x0, flags Z1 C1 N0 V0 (checks Z combine and carry chain).
- ADD 0x7FFFFFFF_FFFFFFFF + 0x1 -> 0x80000000_00000000, N1 V1; SUB 0x0 - 0x1 -> 0xFFFFFFFF_FFFFFFFF, N1 C0 V0.
- EOR 0x12345678_9ABCDEF0 with itself -> 0, Z1; then op=7 -> result 0, resp_err=1, ALU drive stays idle.
- resp_ready held low 5 cycles in DONE: result and flags stable, req_ready=0, new req_valid ignored; accepted only after the resp handshake.
- rst pulsed during HI -> next cycle IDLE, resp_valid=0, req_ready=1; with ALU_SEQ_BYPASS_EN, wide=0 ADD 0xFFFFFFFF+1 -> 0x0, Z1 C1, 1-edge latency.
